acia_host: RTL and testbench

// - Hardware bus initiator for the acia peripheral; replaces 6502 firmware polling on the debug/loopback path.
// - Drives the acia cs/we/rs register bus and polls its status register.
// - Moves bytes between two internal FIFOs (TX-in, RX-out) and the acia data register; exposes valid/ready byte streams to fabric.

---
 rtl/acia_host_if.sv | 27 ++
 rtl/acia_host.sv | 174 +++++++++++++++++
 tb/tb_acia_host.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acia_host_if.sv
// rtl/acia_host_if.sv - acia register bus plus TX/RX byte streams between host and fabric
interface acia_host_if;
  logic       cs;
  logic       we;
  logic       rs;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       irq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  logic       init_done;

  modport master (
    output cs, we, rs, bus_wdata, tx_ready, rx_data, rx_valid, rx_err, init_done,
    input  bus_rdata, irq, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  cs, we, rs, bus_wdata, tx_ready, rx_data, rx_valid, rx_err, init_done,
    output bus_rdata, irq, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/acia_host.sv
// rtl/acia_host.sv - acia bus initiator: init writes, status polling, TX/RX byte FIFOs
// Optional ACIA_HOST_IRQ_EN: irq/TX-driven polling and receive interrupt enable in the config write.
module acia_host #(
  parameter int         FIFO_AW   = 2,
  parameter int         POLL_DIV  = 16,
  parameter logic [7:0] CTRL_INIT = 8'h00
) (
  input logic         clk,
  input logic         rst_n,
  acia_host_if.master bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] L_POLL_MAX = PW'(POLL_DIV - 1);
`ifdef ACIA_HOST_IRQ_EN
  localparam logic [7:0] L_CFG = CTRL_INIT | 8'h80;
`else
  localparam logic [7:0] L_CFG = CTRL_INIT;
`endif

  typedef enum logic [2:0] {
    S_INIT_RST, S_INIT_CFG, S_IDLE, S_STAT_RD,
    S_STAT_WAIT, S_DAT_RD, S_DAT_WAIT, S_TX_WR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_cs, r_we, r_rs;
  logic [7:0]       r_wdata;
  logic             w_cs_nxt, w_we_nxt, w_rs_nxt;
  logic [7:0]       w_wdata_nxt;
  logic             r_snap_txe, r_rx_err, r_init_done;
  logic [PW-1:0]    r_poll;
  logic             w_tx_pop, w_rx_push, w_stat_ld, w_init_set, w_poll_go;

  logic [7:0]       r_tx_mem [DEPTH];
  logic [7:0]       r_rx_mem [DEPTH];
  logic [FIFO_AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic             w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic             w_tx_push, w_rx_pop;
  logic [7:0]       w_tx_head;
  logic [3:0]       w_unused_rdata;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = ((r_tx_wp ^ r_tx_rp) == {1'b1, {FIFO_AW{1'b0}}});
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = ((r_rx_wp ^ r_rx_rp) == {1'b1, {FIFO_AW{1'b0}}});
  assign w_tx_push  = bus.tx_valid & ~w_tx_full;
  assign w_rx_pop   = bus.rx_ready & ~w_rx_empty;
  assign w_tx_head  = r_tx_mem[r_tx_rp[FIFO_AW-1:0]];
  assign w_unused_rdata = {bus.bus_rdata[7:6], bus.bus_rdata[3:2]};

`ifdef ACIA_HOST_IRQ_EN
  assign w_poll_go = bus.irq | ~w_tx_empty;
`else
  logic w_unused_irq;
  assign w_unused_irq = bus.irq;
  assign w_poll_go    = (r_poll == L_POLL_MAX);
`endif

  assign bus.cs        = r_cs;
  assign bus.we        = r_we;
  assign bus.rs        = r_rs;
  assign bus.bus_wdata = r_wdata;
  assign bus.tx_ready  = ~w_tx_full;
  assign bus.rx_valid  = ~w_rx_empty;
  assign bus.rx_data   = r_rx_mem[r_rx_rp[FIFO_AW-1:0]];
  assign bus.rx_err    = r_rx_err;
  assign bus.init_done = r_init_done;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_AW-1:0]] <= bus.tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_AW-1:0]] <= bus.bus_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT_RST;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_rs        <= 1'b0;
      r_wdata     <= 8'h00;
      r_snap_txe  <= 1'b0;
      r_rx_err    <= 1'b0;
      r_init_done <= 1'b0;
      r_poll      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs_nxt;
      r_we    <= w_we_nxt;
      r_rs    <= w_rs_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_stat_ld) r_snap_txe <= bus.bus_rdata[1];
      if (w_stat_ld && (bus.bus_rdata[4] | bus.bus_rdata[5])) r_rx_err <= 1'b1;
      if (w_init_set) r_init_done <= 1'b1;
      if (r_state == S_IDLE && !w_poll_go) r_poll <= r_poll + 1'b1;
      else                                 r_poll <= '0;
    end
  end

  // Access states issue only while cs is low, so each strobe is one cycle with a gap after it;
  // wait states hold through the strobe cycle and sample bus_rdata in the cycle after.
  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_rs_nxt    = 1'b0;
    w_wdata_nxt = r_wdata;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    w_stat_ld   = 1'b0;
    w_init_set  = 1'b0;
    case (r_state)
      S_INIT_RST: if (!r_cs) begin
        w_cs_nxt    = 1'b1;
        w_we_nxt    = 1'b1;
        w_wdata_nxt = 8'h03;
        w_state_nxt = S_INIT_CFG;
      end
      S_INIT_CFG: if (!r_cs) begin
        w_cs_nxt    = 1'b1;
        w_we_nxt    = 1'b1;
        w_wdata_nxt = L_CFG;
        w_init_set  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: if (w_poll_go) w_state_nxt = S_STAT_RD;
      S_STAT_RD: if (!r_cs) begin
        w_cs_nxt    = 1'b1;
        w_state_nxt = S_STAT_WAIT;
      end
      S_STAT_WAIT: if (!r_cs) begin
        w_stat_ld = 1'b1;
        if (bus.bus_rdata[0] && !w_rx_full)       w_state_nxt = S_DAT_RD;
        else if (bus.bus_rdata[1] && !w_tx_empty) w_state_nxt = S_TX_WR;
        else                                      w_state_nxt = S_IDLE;
      end
      S_DAT_RD: if (!r_cs) begin
        w_cs_nxt    = 1'b1;
        w_rs_nxt    = 1'b1;
        w_state_nxt = S_DAT_WAIT;
      end
      S_DAT_WAIT: if (!r_cs) begin
        w_rx_push = ~w_rx_full;
        if (r_snap_txe && !w_tx_empty) w_state_nxt = S_TX_WR;
        else                           w_state_nxt = S_IDLE;
      end
      S_TX_WR: if (!r_cs) begin
        if (!w_tx_empty) begin
          w_cs_nxt    = 1'b1;
          w_we_nxt    = 1'b1;
          w_rs_nxt    = 1'b1;
          w_wdata_nxt = w_tx_head;
          w_tx_pop    = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT_RST;
    endcase
  end
endmodule

// File: tb/tb_acia_host.sv
// tb/tb_acia_host.sv - randomized bench for acia_host against a behavioural acia and stream scoreboard
module tb_acia_host;
  localparam int         FIFO_AW   = 2;
  localparam int         DEPTH     = 4;
  localparam int         POLL_DIV  = 6;
  localparam logic [7:0] CTRL_INIT = 8'h15;
`ifdef ACIA_HOST_IRQ_EN
  localparam logic [7:0] EXP_CFG = 8'h95;
`else
  localparam logic [7:0] EXP_CFG = 8'h15;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acia_host_if bus();
  acia_host #(.FIFO_AW(FIFO_AW), .POLL_DIV(POLL_DIV), .CTRL_INIT(CTRL_INIT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic we; logic rs; logic [7:0] d; int cyc; } acc_t;
  acc_t       log_q[$];
  logic [7:0] acia_rxq[$];
  logic [7:0] rx_got[$];
  logic       acia_txe, irq_man, rx_want, rx_rand, prev_cs;
  logic [1:0] acia_err;
  int         cyc, b2b_viol, n_cmp, n_err;

  // Behavioural acia: answers reads one cycle after the strobe, logs every access, drives rx_ready.
  always @(negedge clk) begin
    acc_t a;
    cyc++;
    if (bus.cs === 1'b1) begin
      if (prev_cs) b2b_viol++;
      a.we = bus.we; a.rs = bus.rs; a.d = bus.bus_wdata; a.cyc = cyc;
      if (bus.we === 1'b0) begin
        if (bus.rs === 1'b0) bus.bus_rdata = {2'b00, acia_err, 2'b00, acia_txe, acia_rxq.size() != 0};
        else if (acia_rxq.size() != 0) bus.bus_rdata = acia_rxq.pop_front();
        else bus.bus_rdata = 8'h00;
        a.d = bus.bus_rdata;
      end
      log_q.push_back(a);
    end
    prev_cs = (bus.cs === 1'b1);
    bus.irq = irq_man | (acia_rxq.size() != 0);
    bus.rx_ready = rx_rand ? 1'($urandom_range(0, 1)) : rx_want;
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) rx_got.push_back(bus.rx_data);
  end

  function automatic int count_acc(input logic we, input logic rs);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we == we && log_q[i].rs == rs) n++;
    return n;
  endfunction

  function automatic int poll_order_viol();
    int v = 0, r = 0, w = 0;
    foreach (log_q[i]) begin
      if (!log_q[i].we && !log_q[i].rs) begin r = 0; w = 0; end
      else if (!log_q[i].we) begin if (r > 0 || w > 0) v++; r++; end
      else if (log_q[i].rs) begin if (w > 0) v++; w++; end
    end
    return v;
  endfunction

  task automatic tx_push(input logic [7:0] b, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (bus.tx_ready === 1'b1) begin bus.tx_data = b; bus.tx_valid = 1'b1; ok = 1; break; end
    end
    @(negedge clk); #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_init;
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (bus.init_done === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL init_done got %b want 1", bus.init_done); end
  endtask

  task automatic test_reset;
    logic [14:0] got;
    repeat (7) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 got = {bus.cs, bus.we, bus.rs, bus.bus_wdata, bus.rx_valid, bus.tx_ready, bus.rx_err, bus.init_done};
    n_cmp++;
    if (got !== {3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_outputs got %h want %h", got, {3'b000, 8'h00, 4'b0100});
    end
    repeat (2) @(negedge clk);
    #1 log_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 40 && log_q.size() < 2; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (log_q.size() < 2) begin n_err++; $display("FAIL init_writes got %0d accesses want 2", log_q.size()); end
    else begin
      n_cmp++;
      if ({log_q[0].we, log_q[0].rs, log_q[0].d} !== {2'b10, 8'h03}) begin
        n_err++; $display("FAIL init_write0 got we=%b rs=%b d=%h want we=1 rs=0 d=03", log_q[0].we, log_q[0].rs, log_q[0].d);
      end
      if ({log_q[1].we, log_q[1].rs, log_q[1].d} !== {2'b10, EXP_CFG}) begin
        n_err++; $display("FAIL init_write1 got we=%b rs=%b d=%h want we=1 rs=0 d=%h", log_q[1].we, log_q[1].rs, log_q[1].d, EXP_CFG);
      end
    end
    wait_init();
  endtask

  task automatic test_rx_single;
    rx_want = 1'b0; acia_txe = 1'b0;
    @(negedge clk); #1;
    log_q.delete(); rx_got.delete();
    acia_rxq.push_back(8'hA5);
    for (int i = 0; i < 100 && bus.rx_valid !== 1'b1; i++) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'hA5}) begin
      n_err++; $display("FAIL rx_single_head got v=%b d=%h want v=1 d=a5", bus.rx_valid, bus.rx_data);
    end
    n_cmp++;
    if (log_q.size() < 2 || {log_q[0].we, log_q[0].rs, log_q[0].d[0]} !== 3'b001 ||
        {log_q[1].we, log_q[1].rs, log_q[1].d} !== {2'b01, 8'hA5}) begin
      n_err++; $display("FAIL rx_single_order got %0d accesses want status read then data read a5", log_q.size());
    end
    rx_want = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (rx_got.size() != 1 || rx_got[0] !== 8'hA5 || count_acc(1'b0, 1'b1) != 1) begin
      n_err++; $display("FAIL rx_single_drain got %0d bytes, %0d data reads want 1 byte a5, 1 read", rx_got.size(), count_acc(1'b0, 1'b1));
    end
  endtask

  task automatic test_tx;
    logic [7:0] exp[$];
    bit ok;
    int wi, n;
    logic [7:0] want;
    acia_txe = 1'b1; rx_want = 1'b1;
    @(negedge clk); #1;
    log_q.delete();
    exp.push_back(8'h3C); exp.push_back(8'h5A);
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
    foreach (exp[i]) begin
      tx_push(exp[i], ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL tx_push byte %0d got not accepted want accepted", i); end
    end
    for (int i = 0; i < 600 && count_acc(1'b1, 1'b1) < exp.size(); i++) @(negedge clk);
    #1;
    wi = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we && log_q[i].rs) begin
        want = (wi < exp.size()) ? exp[wi] : 8'h00;
        n_cmp++;
        if (wi >= exp.size() || log_q[i].d !== want || i == 0 || log_q[i-1].we !== 1'b0 || log_q[i-1].rs !== 1'b0) begin
          n_err++; $display("FAIL tx_write%0d got %h want %h after a status read", wi, log_q[i].d, want);
        end
        wi++;
      end
    end
    n_cmp++;
    if (wi != exp.size()) begin n_err++; $display("FAIL tx_count got %0d writes want %0d", wi, exp.size()); end
    acia_txe = 1'b0;
  endtask

  task automatic test_rx_full;
    logic [7:0] exp[$];
    int k;
    acia_txe = 1'b0; rx_want = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    log_q.delete(); rx_got.delete();
    k = $urandom_range(1, 3);
    for (int i = 0; i < DEPTH + k; i++) begin exp.push_back(8'($urandom)); acia_rxq.push_back(exp[i]); end
    for (int i = 0; i < 400 && count_acc(1'b0, 1'b1) < DEPTH; i++) @(negedge clk);
    repeat (5 * (POLL_DIV + 6)) @(negedge clk);
    #1;
    n_cmp++;
    if (count_acc(1'b0, 1'b1) != DEPTH || acia_rxq.size() != k) begin
      n_err++; $display("FAIL rx_full_stall got %0d data reads, %0d left want %0d reads, %0d left",
                        count_acc(1'b0, 1'b1), acia_rxq.size(), DEPTH, k);
    end
    n_cmp++;
    if (count_acc(1'b0, 1'b0) < DEPTH + 2) begin
      n_err++; $display("FAIL rx_full_polling got %0d status reads want >= %0d", count_acc(1'b0, 1'b0), DEPTH + 2);
    end
    rx_want = 1'b1;
    for (int i = 0; i < 600 && rx_got.size() < exp.size(); i++) @(negedge clk);
    #1;
    n_cmp++;
    if (rx_got.size() != exp.size()) begin n_err++; $display("FAIL rx_full_drain got %0d bytes want %0d", rx_got.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_cmp++;
      if (rx_got[i] !== exp[i]) begin n_err++; $display("FAIL rx_full_byte%0d got %h want %h", i, rx_got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rexp[$];
    logic [7:0] texp[$];
    logic [7:0] wgot[$];
    bit ok;
    int nr, nt;
    @(negedge clk); #1;
    log_q.delete(); rx_got.delete();
    rx_rand = 1'b1; acia_txe = 1'b1;
    nr = $urandom_range(3, 8); nt = $urandom_range(3, 8);
    for (int i = 0; i < nr; i++) begin rexp.push_back(8'($urandom)); acia_rxq.push_back(rexp[i]); end
    for (int i = 0; i < nt; i++) begin texp.push_back(8'($urandom)); tx_push(texp[i], ok); end
    for (int i = 0; i < 2000 && (rx_got.size() < nr || count_acc(1'b1, 1'b1) < nt); i++) @(negedge clk);
    #1;
    foreach (log_q[i]) if (log_q[i].we && log_q[i].rs) wgot.push_back(log_q[i].d);
    n_cmp++;
    if (rx_got != rexp) begin n_err++; $display("FAIL b2b_rx got %0d bytes want %0d in order", rx_got.size(), nr); end
    n_cmp++;
    if (wgot != texp) begin n_err++; $display("FAIL b2b_tx got %0d writes want %0d in order", wgot.size(), nt); end
    n_cmp++;
    if (poll_order_viol() != 0) begin n_err++; $display("FAIL b2b_poll_order got %0d violations want 0", poll_order_viol()); end
    rx_rand = 1'b0; rx_want = 1'b1; acia_txe = 1'b0;
  endtask

  task automatic test_err_and_reset;
    bit ok = 0;
    logic [6:0] got;
    rx_want = 1'b1;
    acia_err = 2'b11;
    acia_rxq.push_back(8'($urandom));
    for (int i = 0; i < 100 && bus.rx_err !== 1'b1; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.rx_err !== 1'b1) begin n_err++; $display("FAIL rx_err_set got %b want 1", bus.rx_err); end
    acia_err = 2'b00;
    repeat (100) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.rx_err !== 1'b1) begin n_err++; $display("FAIL rx_err_sticky got %b want 1", bus.rx_err); end
    log_q.delete();
    acia_rxq.push_back(8'($urandom));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (count_acc(1'b0, 1'b1) != 0) begin ok = 1; break; end
    end
    rst_n = 1'b0;
    #1 got = {bus.cs, bus.we, bus.rs, bus.rx_valid, bus.rx_err, bus.init_done, bus.tx_ready};
    n_cmp++;
    if (!ok || got !== 7'b0000001) begin
      n_err++; $display("FAIL reset_mid_dat_wait got seen=%0d outs=%b want seen=1 outs=0000001", ok, got);
    end
    acia_rxq.delete();
    repeat (2) @(negedge clk);
    #1 log_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 40 && log_q.size() < 1; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (log_q.size() < 1 || {log_q[0].we, log_q[0].rs, log_q[0].d} !== {2'b10, 8'h03}) begin
      n_err++; $display("FAIL restart_init got %0d accesses want first = ctrl write 03", log_q.size());
    end
    wait_init();
  endtask

`ifdef ACIA_HOST_IRQ_EN
  task automatic test_irq;
    acia_txe = 1'b0;
    @(negedge clk); #1;
    log_q.delete();
    repeat (1000) @(negedge clk);
    #1;
    n_cmp++;
    if (log_q.size() != 0) begin n_err++; $display("FAIL irq_quiet got %0d accesses want 0", log_q.size()); end
    irq_man = 1'b1; bus.irq = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (count_acc(1'b0, 1'b0) < 1) begin n_err++; $display("FAIL irq_status_read got 0 status reads want 1 within 2 cycles"); end
    irq_man = 1'b0;
    repeat (10) @(negedge clk);
  endtask
`else
  task automatic test_poll_interval;
    int iv;
    acia_txe = 1'b0;
    @(negedge clk); #1;
    log_q.delete();
    for (int i = 0; i < 200 && count_acc(1'b0, 1'b0) < 4; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (log_q.size() < 4) begin n_err++; $display("FAIL poll_count got %0d status reads want 4", log_q.size()); end
    else for (int i = 1; i < 4; i++) begin
      iv = log_q[i].cyc - log_q[i-1].cyc;
      n_cmp++;
      if (iv < POLL_DIV + 1 || iv > POLL_DIV + 4) begin
        n_err++; $display("FAIL poll_interval%0d got %0d want %0d..%0d", i, iv, POLL_DIV + 1, POLL_DIV + 4);
      end
    end
  endtask
`endif

  task automatic test_bus_spacing;
    n_cmp++;
    if (b2b_viol != 0) begin n_err++; $display("FAIL bus_spacing got %0d back-to-back strobes want 0", b2b_viol); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; b2b_viol = 0; prev_cs = 1'b0;
    acia_txe = 1'b0; acia_err = 2'b00; irq_man = 1'b0; rx_want = 1'b0; rx_rand = 1'b0;
    bus.bus_rdata = 8'h00; bus.irq = 1'b0; bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_rx_single();
    test_tx();
    test_rx_full();
    test_back_to_back();
`ifdef ACIA_HOST_IRQ_EN
    test_irq();
`else
    test_poll_interval();
`endif
    test_err_and_reset();
    test_bus_spacing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
